// File: rtl/acc_pkg.sv
// Shared types and helpers for the accumulator bank: FSM encoding,
// bank-op selection and two's-complement saturation bounds.
package acc_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  // Bank operation applied at an edge; encoded in falling priority order.
  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_CLR  = 2'd1,
    OP_LOAD = 2'd2,
    OP_ACC  = 2'd3
  } bank_op_e;

  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/acc_requant.sv
// Drain requantiser: arithmetic right shift with round-half-up, then a
// saturating narrow from ACC_W to OUT_W.
module acc_requant
  import acc_pkg::*;
#(
  parameter int ACC_W   = 16,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 4
) (
  input  logic [ACC_W-1:0]   lane_i,
  input  logic [SHIFT_W-1:0] shift_i,
  output logic [OUT_W-1:0]   data_o,
  output logic               sat_o
);

  localparam logic signed [ACC_W:0] OMAX = (ACC_W+1)'(sat_max(OUT_W));
  localparam logic signed [ACC_W:0] OMIN = (ACC_W+1)'(sat_min(OUT_W));

  logic signed [ACC_W:0] ext, rnd, sum, v;

  // One extra bit keeps lane + 2^(s-1) from wrapping; s=0 degenerates to v=lane.
  always_comb begin
    ext = {lane_i[ACC_W-1], lane_i};
    rnd = '0;
    if (shift_i != '0) rnd = (ACC_W+1)'(1) << (shift_i - 1'b1);
    sum = ext + rnd;
    v   = sum >>> shift_i;
    if (v > OMAX) begin
      data_o = OMAX[OUT_W-1:0];
      sat_o  = 1'b1;
    end else if (v < OMIN) begin
      data_o = OMIN[OUT_W-1:0];
      sat_o  = 1'b1;
    end else begin
      data_o = v[OUT_W-1:0];
      sat_o  = 1'b0;
    end
  end

endmodule

// File: rtl/acc_array.sv
// Multi-lane saturating accumulator bank with sticky saturation flags and a
// serial, requantising drain over a valid/ready handshake.
module acc_array
  import acc_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int IN_W    = 8,
  parameter int ACC_W   = 16,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 4,
  localparam int LW     = $clog2(LANES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   acc_clr,
  input  logic                   load_vld,
  input  logic [LANES*ACC_W-1:0] load_data,
  input  logic                   acc_vld,
  input  logic [LANES-1:0]       acc_mask,
  input  logic [LANES*IN_W-1:0]  acc_data,
  input  logic                   drain_start,
  input  logic [SHIFT_W-1:0]     drain_shift,
  input  logic                   drain_clr,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic [LW-1:0]          out_lane,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_sat,
  output logic [LANES-1:0]       acc_sat,
  output logic                   busy
);

  localparam logic [ACC_W-1:0] AMAX = ACC_W'(sat_max(ACC_W));
  localparam logic [ACC_W-1:0] AMIN = ACC_W'(sat_min(ACC_W));
  localparam logic [LW-1:0]    LAST = LW'(LANES - 1);

  state_e                        state_q, state_d;
  logic [LW-1:0]                 idx_q, idx_d;
  logic [SHIFT_W-1:0]            shift_q;
  logic                          clr_q;
  logic [LANES-1:0][ACC_W-1:0]   lane_q, lane_d;
  logic [LANES-1:0]              sat_q, sat_d;
  logic [LANES-1:0][ACC_W-1:0]   acc_res_w;
  logic [LANES-1:0]              ovf_w;
  bank_op_e                      op;
  logic                          hs, last_hs;

  assign busy     = (state_q == ST_DRAIN);
  assign out_vld  = busy;
  assign out_lane = idx_q;
  assign acc_sat  = sat_q;
  assign hs       = out_vld & out_rdy;
  assign last_hs  = hs & (idx_q == LAST);

  // Per-lane saturating adder; overflow shows as the two top sum bits differing.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic signed [ACC_W:0] sum;
    assign sum = signed'({lane_q[k][ACC_W-1], lane_q[k]})
               + signed'({{(ACC_W+1-IN_W){acc_data[k*IN_W+IN_W-1]}}, acc_data[k*IN_W +: IN_W]});
    assign ovf_w[k]     = sum[ACC_W] ^ sum[ACC_W-1];
    assign acc_res_w[k] = ovf_w[k] ? (sum[ACC_W] ? AMIN : AMAX) : sum[ACC_W-1:0];
  end

  // Bank ops only in IDLE; the single DRAIN-side op is the post-drain clear.
  always_comb begin
    op = OP_NONE;
    if (state_q == ST_IDLE) begin
      if (acc_clr)       op = OP_CLR;
      else if (load_vld) op = OP_LOAD;
      else if (acc_vld)  op = OP_ACC;
    end else if (last_hs && clr_q) begin
      op = OP_CLR;
    end
  end

  always_comb begin
    lane_d = lane_q;
    sat_d  = sat_q;
    unique case (op)
      OP_CLR: begin
        lane_d = '0;
        sat_d  = '0;
      end
      OP_LOAD: begin
        lane_d = load_data;
        sat_d  = '0;
      end
      OP_ACC: begin
        for (int k = 0; k < LANES; k++) begin
          if (acc_mask[k]) begin
            lane_d[k] = acc_res_w[k];
            sat_d[k]  = sat_q[k] | ovf_w[k];
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (drain_start) begin
          state_d = ST_DRAIN;
          idx_d   = '0;
        end
      end
      ST_DRAIN: begin
        if (last_hs) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else if (hs) begin
          idx_d = idx_q + LW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      shift_q <= '0;
      clr_q   <= 1'b0;
      lane_q  <= '0;
      sat_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      sat_q   <= sat_d;
      if (state_q == ST_IDLE && drain_start) begin
        shift_q <= drain_shift;
        clr_q   <= drain_clr;
      end
    end
  end

  acc_requant #(
    .ACC_W  (ACC_W),
    .OUT_W  (OUT_W),
    .SHIFT_W(SHIFT_W)
  ) u_requant (
    .lane_i (lane_q[idx_q]),
    .shift_i(shift_q),
    .data_o (out_data),
    .sat_o  (out_sat)
  );

endmodule

// File: tb/tb_acc_array.sv
// Directed bench for acc_array: saturation, mask/priority, requantised drain,
// backpressure, start collision with drain_clr, and reset mid-drain.
module tb_acc_array;

  localparam int LANES = 4, IN_W = 8, ACC_W = 16, OUT_W = 8, SHIFT_W = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   acc_clr, load_vld, acc_vld, drain_start, drain_clr, out_rdy;
  logic [LANES*ACC_W-1:0] load_data;
  logic [LANES-1:0]       acc_mask;
  logic [LANES*IN_W-1:0]  acc_data;
  logic [SHIFT_W-1:0]     drain_shift;
  logic                   out_vld, out_sat, busy;
  logic [1:0]             out_lane;
  logic [OUT_W-1:0]       out_data;
  logic [LANES-1:0]       acc_sat;

  int checks = 0;
  int errors = 0;

  acc_array #(.LANES(LANES), .IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)) dut (
    .clk(clk), .rst_n(rst_n), .acc_clr(acc_clr), .load_vld(load_vld), .load_data(load_data),
    .acc_vld(acc_vld), .acc_mask(acc_mask), .acc_data(acc_data), .drain_start(drain_start),
    .drain_shift(drain_shift), .drain_clr(drain_clr), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_lane(out_lane), .out_data(out_data), .out_sat(out_sat), .acc_sat(acc_sat), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_lanes(input string tag, input logic [15:0] l3, input logic [15:0] l2,
                           input logic [15:0] l1, input logic [15:0] l0);
    chk({tag, ".l0"}, 32'(dut.lane_q[0]), 32'(l0));
    chk({tag, ".l1"}, 32'(dut.lane_q[1]), 32'(l1));
    chk({tag, ".l2"}, 32'(dut.lane_q[2]), 32'(l2));
    chk({tag, ".l3"}, 32'(dut.lane_q[3]), 32'(l3));
  endtask

  task automatic chk_out(input string tag, input logic [1:0] lane, input logic [7:0] data,
                         input logic sat);
    chk({tag, ".vld"},  32'(out_vld),  32'd1);
    chk({tag, ".lane"}, 32'(out_lane), 32'(lane));
    chk({tag, ".data"}, 32'(out_data), 32'(data));
    chk({tag, ".sat"},  32'(out_sat),  32'(sat));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    acc_clr = 0; load_vld = 0; acc_vld = 0; drain_start = 0; drain_clr = 0;
    acc_mask = '0; acc_data = '0; load_data = '0; drain_shift = '0;
  endtask

  initial begin
    idle_inputs();
    out_rdy = 1'b1;
    rst_n   = 1'b0;
    #12;
    chk("rst.vld",  32'(out_vld), 32'd0);
    chk("rst.busy", 32'(busy),    32'd0);
    chk("rst.sat",  32'(acc_sat), 32'd0);
    chk_lanes("rst", 16'h0, 16'h0, 16'h0, 16'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 1. positive saturation
    load_vld = 1; load_data = {16'h0, 16'h0, 16'h0, 16'h7F00};
    tick(); idle_inputs();
    chk_lanes("s1.load", 16'h0, 16'h0, 16'h0, 16'h7F00);
    acc_vld = 1; acc_mask = 4'b0001; acc_data = {8'h0, 8'h0, 8'h0, 8'h7F};
    tick();
    chk("s1.a1", 32'(dut.lane_q[0]), 32'h7F7F); chk("s1.a1sat", 32'(acc_sat), 32'h0);
    tick();
    chk("s1.a2", 32'(dut.lane_q[0]), 32'h7FFE); chk("s1.a2sat", 32'(acc_sat), 32'h0);
    tick();
    chk("s1.a3", 32'(dut.lane_q[0]), 32'h7FFF); chk("s1.a3sat", 32'(acc_sat), 32'h1);
    idle_inputs(); acc_clr = 1;
    tick(); idle_inputs();
    chk("s1.clr", 32'(dut.lane_q[0]), 32'h0); chk("s1.clrsat", 32'(acc_sat), 32'h0);

    // 2. mask, negative saturation, priority
    acc_vld = 1; acc_mask = 4'b0101; acc_data = {8'h01, 8'h01, 8'h01, 8'h01};
    tick(); idle_inputs();
    chk_lanes("s2.mask", 16'h0, 16'h1, 16'h0, 16'h1);
    load_vld = 1; load_data = {16'h0, 16'h0, 16'h8005, 16'h0};
    tick(); idle_inputs();
    acc_vld = 1; acc_mask = 4'b0010; acc_data = {8'h0, 8'h0, 8'hF6, 8'h0};
    tick(); idle_inputs();
    chk("s2.neg", 32'(dut.lane_q[1]), 32'h8000); chk("s2.negsat", 32'(acc_sat), 32'h2);
    acc_clr = 1; acc_vld = 1; acc_mask = 4'b1111; acc_data = {8'h01, 8'h01, 8'h01, 8'h01};
    tick(); idle_inputs();
    chk_lanes("s2.clracc", 16'h0, 16'h0, 16'h0, 16'h0);
    load_vld = 1; load_data = {16'h4, 16'h3, 16'h2, 16'h1};
    acc_vld = 1; acc_mask = 4'b1111; acc_data = {8'h01, 8'h01, 8'h01, 8'h01};
    tick(); idle_inputs();
    chk_lanes("s2.ldacc", 16'h4, 16'h3, 16'h2, 16'h1);

    // 3. drain requant, shift 4
    load_vld = 1; load_data = {16'h8000, 16'h1000, 16'hFFE8, 16'h0018};
    tick(); idle_inputs();
    drain_start = 1; drain_shift = 4'd4;
    tick(); idle_inputs();
    chk("s3.busy", 32'(busy), 32'd1);
    chk_out("s3.o0", 2'd0, 8'h02, 1'b0); tick();
    chk_out("s3.o1", 2'd1, 8'hFF, 1'b0); tick();
    chk_out("s3.o2", 2'd2, 8'h7F, 1'b1); tick();
    chk_out("s3.o3", 2'd3, 8'h80, 1'b1); tick();
    chk("s3.done", 32'(out_vld), 32'd0);
    chk_lanes("s3.kept", 16'h8000, 16'h1000, 16'hFFE8, 16'h0018);

    // 4. backpressure and ignored bank ops during drain
    drain_start = 1; drain_shift = 4'd0;
    tick(); idle_inputs();
    chk_out("s4.o0", 2'd0, 8'h18, 1'b0);
    tick();
    out_rdy = 0; acc_vld = 1; acc_clr = 1; acc_mask = 4'b1111;
    acc_data = {8'h7F, 8'h7F, 8'h7F, 8'h7F};
    for (int i = 0; i < 3; i++) begin
      chk_out("s4.hold", 2'd1, 8'hE8, 1'b0);
      tick();
    end
    chk_out("s4.hold", 2'd1, 8'hE8, 1'b0);
    idle_inputs(); out_rdy = 1;
    tick(); tick(); tick();
    chk("s4.done", 32'(busy), 32'd0);
    chk_lanes("s4.kept", 16'h8000, 16'h1000, 16'hFFE8, 16'h0018);
    chk("s4.sat", 32'(acc_sat), 32'h0);

    // 5. start collision with accumulate, drain_clr
    load_vld = 1; load_data = {16'h7FFF, 16'h0, 16'h0, 16'd10};
    tick(); idle_inputs();
    acc_vld = 1; acc_mask = 4'b1000; acc_data = {8'h01, 8'h0, 8'h0, 8'h0};
    tick(); idle_inputs();
    chk("s5.sat3", 32'(acc_sat), 32'h8);
    drain_start = 1; drain_clr = 1; drain_shift = 4'd0;
    acc_vld = 1; acc_mask = 4'b0001; acc_data = {8'h0, 8'h0, 8'h0, 8'h05};
    tick(); idle_inputs();
    chk_out("s5.o0", 2'd0, 8'h0F, 1'b0); tick();
    chk_out("s5.o1", 2'd1, 8'h00, 1'b0); tick();
    chk_out("s5.o2", 2'd2, 8'h00, 1'b0); tick();
    chk_out("s5.o3", 2'd3, 8'h7F, 1'b1);
    chk("s5.sat_pre", 32'(acc_sat), 32'h8);
    tick();
    chk("s5.busy", 32'(busy), 32'd0);
    chk("s5.sat", 32'(acc_sat), 32'h0);
    chk_lanes("s5.clr", 16'h0, 16'h0, 16'h0, 16'h0);

    // 6. reset mid-drain
    load_vld = 1; load_data = {16'h4, 16'h3, 16'h2, 16'h1};
    tick(); idle_inputs();
    drain_start = 1; drain_clr = 1;
    tick(); idle_inputs();
    tick(); tick();
    chk_out("s6.o2", 2'd2, 8'h03, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("s6.vld",  32'(out_vld), 32'd0);
    chk("s6.busy", 32'(busy),    32'd0);
    chk_lanes("s6.rst", 16'h0, 16'h0, 16'h0, 16'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    drain_start = 1;
    tick(); idle_inputs();
    chk_out("s6.z0", 2'd0, 8'h00, 1'b0);
    tick(); tick(); tick(); tick();
    chk("s6.end", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_array.md
Name: acc_array

Overview:
- Multi-lane saturating accumulator bank with per-lane enable mask, bulk load/clear and sticky saturation flags.
- Adds a requantising drain path: arithmetic shift, round-half-up, saturating narrow.
- The drain emits lanes serially over a valid/ready handshake.
- Sits between the MAC datapath and the output writeback buffer, and replaces single-lane fixed-width accumulators.

Parameters:
- LANES, 4, number of independent accumulator lanes (>=2).
- IN_W, 8, signed width of each incoming addend.
- ACC_W, 16, signed accumulator width (ACC_W > IN_W).
- OUT_W, 8, signed width of the drained, requantised value (OUT_W <= ACC_W).
- SHIFT_W, 4, width of the drain shift amount; shift values >= ACC_W are illegal.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- acc_clr  in  1  zero all lanes and all sat flags
- load_vld  in  1  load all lanes from load_data
- load_data  in  LANES*ACC_W  packed signed values; lane k at [k*ACC_W +: ACC_W]
- acc_vld  in  1  accumulate acc_data into the masked lanes
- acc_mask  in  LANES  per-lane accumulate enable
- acc_data  in  LANES*IN_W  packed signed addends
- drain_start  in  1  begin serial drain; sampled only in IDLE
- drain_shift  in  SHIFT_W  right-shift amount, captured at drain_start
- drain_clr  in  1  clear the bank after the drain; captured at drain_start
- out_vld  out  1  drain output valid
- out_rdy  in  1  downstream ready
- out_lane  out  log2(LANES)  lane index of out_data
- out_data  out  OUT_W  requantised lane value
- out_sat  out  1  out_data was clipped during narrowing
- acc_sat  out  LANES  sticky per-lane accumulate saturation flag
- busy  out  1  high in DRAIN

Behaviour:
- Reset (async, rst_n=0): all lanes 0, acc_sat 0, FSM IDLE, lane index 0, captured shift/clr 0, out_vld 0, busy 0.
- FSM states are IDLE and DRAIN.
- In IDLE, bank ops apply at the clock edge with priority acc_clr > load_vld > acc_vld. Lower-priority ops in the same cycle are dropped.
- Accumulate:
  - Sign-extend acc_data lane to ACC_W+1 and add to the lane value.
  - On positive overflow, result is 2^(ACC_W-1)-1. On negative overflow, result is -2^(ACC_W-1). In both cases acc_sat[k] is set.
  - Unmasked lanes hold their value and flag.
- acc_sat[k] is sticky and cleared only by acc_clr, load_vld or a drain_clr completion.
- Reads of lane state see the post-edge value; there is no bypass.
- IDLE -> DRAIN on drain_start:
  - Capture drain_shift and drain_clr; set lane index 0.
  - A bank op issued in the same cycle as drain_start is applied at that edge, so the drain sees the updated values.
- DRAIN:
  - busy=1, out_vld=1, out_lane=lane index.
  - out_data and out_sat are combinational from the frozen lane[out_lane].
  - acc_clr, load_vld, acc_vld and drain_start are ignored.
- Handshake:
  - The index advances only on out_vld & out_rdy.
  - out_lane, out_data and out_sat stay stable while out_rdy=0.
  - out_vld never drops without a handshake.
- Last lane (LANES-1) handshake: go to IDLE and set out_vld=0 next cycle. If the captured drain_clr=1, zero all lanes and acc_sat at that same edge.
- Latency: drain_start at edge t gives lane 0 valid in the cycle after t. With out_rdy held high, one lane per cycle, LANES cycles total.
- Requant (s = captured shift):
  - If s=0, v = lane.
  - Otherwise v = (lane + 2^(s-1)) >>> s, computed in ACC_W+1 bits with no wrap.
  - If v > 2^(OUT_W-1)-1, out_data is that max and out_sat=1.
  - If v < -2^(OUT_W-1), out_data is that min and out_sat=1.
  - Otherwise out_data = v[OUT_W-1:0] and out_sat=0.
- Reset asserted mid-drain aborts immediately to the reset state. No partial clear applies.

Decomposition:
- Shared package acc_pkg holds:
  - FSM state encoding (ST_IDLE, ST_DRAIN);
  - bank-op priority constants;
  - saturation bound functions sat_max(w)/sat_min(w).
- One combinational sub-module, acc_requant (params ACC_W, OUT_W, SHIFT_W): lane value and shift in, out_data and out_sat out. Instantiated once, muxed by lane index.
- The per-lane saturating adder is a generate loop in acc_array; it is not a separate module.

Test Plan:
All scenarios use LANES=4, IN_W=8, ACC_W=16, OUT_W=8.
1. Positive saturation: load lane0=0x7F00, acc mask=0001 with data 127 three times -> lane0 0x7F7F, 0x7FFE, 0x7FFF; acc_sat[0]=1 only after the third. Then acc_clr -> lane0=0, acc_sat=0.
2. Mask and priority: mask=0101, all addends +1 -> lanes {0,1,0,1} (lane3..lane0). Same cycle acc_clr=1 + acc_vld=1 -> all 0. load_vld + acc_vld -> load value only.
3. Drain requant: lanes = 0x0018, 0xFFE8, 0x1000, 0x8000 with shift 4. Out lanes 0..3 = 0x02/sat0, 0xFF/sat0, 0x7F/sat1, 0x80/sat1; out_vld high exactly 4 cycles with out_rdy=1.
4. Backpressure: drain with out_rdy=0 for 3 cycles at lane1 -> out_lane=1 and out_data stable. acc_vld pulsed during DRAIN -> lane values unchanged after drain.
5. Start collision and drain_clr: drain_start + acc_vld (lane0 +5 from 10) same cycle, drain_clr=1, shift=0 -> lane0 out 0x0F. After last handshake, all lanes 0, acc_sat 0, busy 0.
6. Reset mid-drain: rst_n low during lane2 -> out_vld=0, busy=0 and lanes 0 asynchronously. After release, drain_start drains zeros from lane 0.
